// File: rtl/video_pkg.sv
// Shared constants and types for the video processing pipe: colour-operation
// modes, luma coefficients and the fixed input-to-output latency.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_GRAY   = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_INV    = 2'd3
    } mode_e;

    // Luma weights sum to 256, so (sum of products) >> 8 never exceeds full scale.
    localparam int COEF_R = 77;
    localparam int COEF_G = 150;
    localparam int COEF_B = 29;

    localparam int LAT    = 3;
    localparam int SYNC_W = 3;

endpackage

// File: rtl/video_sync_delay.sv
// Shift register carrying {de, hsync, vsync} alongside the pixel pipeline.
// Also exposes the de bit one stage early so the last data stage can mask RGB.
module video_sync_delay
    import video_pkg::*;
#(
    parameter int DEPTH = LAT,
    parameter int W     = SYNC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         de_pre
);

    logic [DEPTH-1:0][W-1:0] stage_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[DEPTH-2:0], din};
        end
    end

    assign dout   = stage_reg[DEPTH-1];
    assign de_pre = stage_reg[DEPTH-2][W-1];

endmodule

// File: rtl/video_proc_pipe.sv
// Three-stage RGB processing (pass/gray/threshold/invert) with frame-shadowed
// config, aligned syncs and output coordinate counters. Optional ROI border
// overlay is compiled in when VIDEO_ROI_BOX_EN is defined.
module video_proc_pipe
    import video_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int H_ACT  = 64,
    parameter int V_ACT  = 64,
    parameter int FCNT_W = 16
) (
    input  logic                     rx_pclk,
    input  logic                     rst_n,
    input  logic                     rx_de,
    input  logic                     rx_hsync,
    input  logic                     rx_vsync,
    input  logic [DATA_W-1:0]        rx_red,
    input  logic [DATA_W-1:0]        rx_green,
    input  logic [DATA_W-1:0]        rx_blue,
    input  logic [1:0]               cfg_mode,
    input  logic [DATA_W-1:0]        cfg_thr,
`ifdef VIDEO_ROI_BOX_EN
    input  logic [$clog2(H_ACT)-1:0] roi_x0,
    input  logic [$clog2(H_ACT)-1:0] roi_x1,
    input  logic [$clog2(V_ACT)-1:0] roi_y0,
    input  logic [$clog2(V_ACT)-1:0] roi_y1,
`endif
    output logic                     tx_de,
    output logic                     tx_hsync,
    output logic                     tx_vsync,
    output logic [DATA_W-1:0]        tx_red,
    output logic [DATA_W-1:0]        tx_green,
    output logic [DATA_W-1:0]        tx_blue,
    output logic [$clog2(H_ACT)-1:0] tx_x,
    output logic [$clog2(V_ACT)-1:0] tx_y,
    output logic [FCNT_W-1:0]        frame_cnt
);

    localparam int XW = $clog2(H_ACT);
    localparam int YW = $clog2(V_ACT);
    localparam int PW = DATA_W + 8;
    localparam int SW = DATA_W + 10;
    localparam logic [XW-1:0]     X_MAX   = XW'(H_ACT - 1);
    localparam logic [YW-1:0]     Y_MAX   = YW'(V_ACT - 1);
    localparam logic [DATA_W-1:0] THR_RST = DATA_W'(1) << (DATA_W - 1);

    logic              vs_d_reg;
    logic              vs_rise;
    mode_e             act_mode_reg;
    logic [DATA_W-1:0] act_thr_reg;
    logic [FCNT_W-1:0] frame_cnt_reg;

    assign vs_rise = rx_vsync & ~vs_d_reg;

    always_ff @(posedge rx_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_reg      <= 1'b0;
            act_mode_reg  <= MODE_PASS;
            act_thr_reg   <= THR_RST;
            frame_cnt_reg <= '0;
        end else begin
            vs_d_reg <= rx_vsync;
            if (vs_rise) begin
                act_mode_reg  <= mode_e'(cfg_mode);
                act_thr_reg   <= cfg_thr;
                frame_cnt_reg <= frame_cnt_reg + FCNT_W'(1);
            end
        end
    end

    assign frame_cnt = frame_cnt_reg;

`ifdef VIDEO_ROI_BOX_EN
    logic [XW-1:0] act_x0_reg, act_x1_reg;
    logic [YW-1:0] act_y0_reg, act_y1_reg;

    always_ff @(posedge rx_pclk or negedge rst_n) begin
        if (!rst_n) begin
            act_x0_reg <= '0;
            act_x1_reg <= '0;
            act_y0_reg <= '0;
            act_y1_reg <= '0;
        end else if (vs_rise) begin
            act_x0_reg <= roi_x0;
            act_x1_reg <= roi_x1;
            act_y0_reg <= roi_y0;
            act_y1_reg <= roi_y1;
        end
    end
`endif

    // Mode and threshold travel with each pixel so a vsync edge never
    // retargets pixels that are already in flight.
    mode_e             mode1_reg, mode2_reg;
    logic [DATA_W-1:0] thr1_reg, thr2_reg, luma2_reg;
    logic [DATA_W-1:0] rx_pix   [3];
    logic [PW-1:0]     prod1    [3];
    logic [DATA_W-1:0] chan_out [3];

    assign rx_pix[0] = rx_red;
    assign rx_pix[1] = rx_green;
    assign rx_pix[2] = rx_blue;

    always_ff @(posedge rx_pclk or negedge rst_n) begin
        if (!rst_n) begin
            mode1_reg <= MODE_PASS;
            mode2_reg <= MODE_PASS;
            thr1_reg  <= '0;
            thr2_reg  <= '0;
            luma2_reg <= '0;
        end else begin
            mode1_reg <= act_mode_reg;
            mode2_reg <= mode1_reg;
            thr1_reg  <= act_thr_reg;
            thr2_reg  <= thr1_reg;
            luma2_reg <= DATA_W'((SW'(prod1[0]) + SW'(prod1[1]) + SW'(prod1[2])) >> 8);
        end
    end

    // Sync delay and output-side coordinate counters.
    logic [SYNC_W-1:0] sync_out;
    logic              de_pre;

    video_sync_delay #(.DEPTH(LAT), .W(SYNC_W)) u_sync_delay (
        .clk    (rx_pclk),
        .rst_n  (rst_n),
        .din    ({rx_de, rx_hsync, rx_vsync}),
        .dout   (sync_out),
        .de_pre (de_pre)
    );

    assign {tx_de, tx_hsync, tx_vsync} = sync_out;

    logic          tx_de_d_reg, tx_vs_d_reg;
    logic          de_fall, tx_vs_rise;
    logic [XW-1:0] x_reg, x_next;
    logic [YW-1:0] y_reg, y_next;

    assign de_fall    = ~tx_de & tx_de_d_reg;
    assign tx_vs_rise = tx_vsync & ~tx_vs_d_reg;

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (de_fall) begin
            x_next = '0;
        end else if (tx_de && (x_reg != X_MAX)) begin
            x_next = x_reg + XW'(1);
        end
        if (tx_vs_rise) begin
            y_next = '0;
        end else if (de_fall && (y_reg != Y_MAX)) begin
            y_next = y_reg + YW'(1);
        end
    end

    always_ff @(posedge rx_pclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_de_d_reg <= 1'b0;
            tx_vs_d_reg <= 1'b0;
            x_reg       <= '0;
            y_reg       <= '0;
        end else begin
            tx_de_d_reg <= tx_de;
            tx_vs_d_reg <= tx_vsync;
            x_reg       <= x_next;
            y_reg       <= y_next;
        end
    end

    assign tx_x = x_reg;
    assign tx_y = y_reg;

`ifdef VIDEO_ROI_BOX_EN
    // x_next/y_next is the coordinate the stage-2 pixel will carry at the output.
    logic border_next;

    always_comb begin
        border_next = de_pre &&
            ((((x_next == act_x0_reg) || (x_next == act_x1_reg)) &&
              (y_next >= act_y0_reg) && (y_next <= act_y1_reg)) ||
             (((y_next == act_y0_reg) || (y_next == act_y1_reg)) &&
              (x_next >= act_x0_reg) && (x_next <= act_x1_reg)));
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            localparam int COEF = (gi == 0) ? COEF_R : ((gi == 1) ? COEF_G : COEF_B);

            logic [DATA_W-1:0] pix1_reg, pix2_reg, out_reg, out_next;
            logic [PW-1:0]     prod1_reg;

            always_ff @(posedge rx_pclk or negedge rst_n) begin
                if (!rst_n) begin
                    pix1_reg  <= '0;
                    pix2_reg  <= '0;
                    prod1_reg <= '0;
                    out_reg   <= '0;
                end else begin
                    pix1_reg  <= rx_pix[gi];
                    prod1_reg <= PW'(COEF) * PW'(rx_pix[gi]);
                    pix2_reg  <= pix1_reg;
                    out_reg   <= out_next;
                end
            end

            always_comb begin
                out_next = '0;
                if (de_pre) begin
                    case (mode2_reg)
                        MODE_PASS:   out_next = pix2_reg;
                        MODE_GRAY:   out_next = luma2_reg;
                        MODE_THRESH: out_next = (luma2_reg >= thr2_reg) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
                        MODE_INV:    out_next = ~pix2_reg;
                        default:     out_next = pix2_reg;
                    endcase
`ifdef VIDEO_ROI_BOX_EN
                    if (border_next) begin
                        out_next = (gi == 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
                    end
`endif
                end
            end

            assign prod1[gi]    = prod1_reg;
            assign chan_out[gi] = out_reg;
        end
    endgenerate

    assign tx_red   = chan_out[0];
    assign tx_green = chan_out[1];
    assign tx_blue  = chan_out[2];

endmodule

// File: tb/tb_video_proc_pipe.sv
// Self-checking bench for video_proc_pipe (H_ACT=4, V_ACT=3): a frame-level
// model predicts every output cycle; literal values pin key pixels. Builds with or without VIDEO_ROI_BOX_EN.
module tb_video_proc_pipe;

    localparam int DW    = 8;
    localparam int HA    = 4;
    localparam int VA    = 3;
    localparam int FW    = 16;
    localparam int NSLOT = 2048;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       de = 1'b0, hs = 1'b0, vs = 1'b0;
    logic [7:0] r = '0, g = '0, b = '0;
    logic [1:0] mode = 2'd0;
    logic [7:0] thr = 8'h80;
    logic [1:0] x0 = 2'd3, x1 = 2'd3, y0 = 2'd2, y1 = 2'd2;

    logic        tx_de, tx_hsync, tx_vsync;
    logic [7:0]  tx_red, tx_green, tx_blue;
    logic [1:0]  tx_x, tx_y;
    logic [15:0] frame_cnt;

    video_proc_pipe #(.DATA_W(DW), .H_ACT(HA), .V_ACT(VA), .FCNT_W(FW)) dut (
        .rx_pclk   (clk),
        .rst_n     (rst_n),
        .rx_de     (de),
        .rx_hsync  (hs),
        .rx_vsync  (vs),
        .rx_red    (r),
        .rx_green  (g),
        .rx_blue   (b),
        .cfg_mode  (mode),
        .cfg_thr   (thr),
`ifdef VIDEO_ROI_BOX_EN
        .roi_x0    (x0),
        .roi_x1    (x1),
        .roi_y0    (y0),
        .roi_y1    (y1),
`endif
        .tx_de     (tx_de),
        .tx_hsync  (tx_hsync),
        .tx_vsync  (tx_vsync),
        .tx_red    (tx_red),
        .tx_green  (tx_green),
        .tx_blue   (tx_blue),
        .tx_x      (tx_x),
        .tx_y      (tx_y),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_vec = 0;
    int n_err = 0;

    // Expected outputs, indexed by the number of rising edges seen.
    bit    ev [NSLOT];
    bit    e_de [NSLOT], e_hs [NSLOT], e_vs [NSLOT];
    int    e_r [NSLOT], e_g [NSLOT], e_b [NSLOT], e_x [NSLOT], e_y [NSLOT];
    bit    fv [NSLOT];
    int    e_fc [NSLOT];
    bit    lv [NSLOT];
    int    l_rgb [NSLOT];
    string l_name [NSLOT];

    // Frame-level model state.
    int m_mode, m_thr, m_fc, m_pix, m_line;
    int m_x0, m_x1, m_y0, m_y1;
    bit m_prev_vs, m_prev_de;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int luma(input int rr, input int gg, input int bb);
        return (77 * rr + 150 * gg + 29 * bb) / 256;
    endfunction

    task automatic reset_model();
        m_mode = 0; m_thr = 128; m_fc = 0; m_pix = 0; m_line = 0;
        m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
        m_prev_vs = 1'b0; m_prev_de = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ev[edge_n + k] = 1'b1;
            e_de[edge_n + k] = 1'b0; e_hs[edge_n + k] = 1'b0; e_vs[edge_n + k] = 1'b0;
            e_r[edge_n + k] = 0; e_g[edge_n + k] = 0; e_b[edge_n + k] = 0;
            lv[edge_n + k] = 1'b0;
        end
        fv[edge_n] = 1'b1;
        e_fc[edge_n] = 0;
    endtask

    task automatic set_lit(input int v, input string nm);
        lv[edge_n + 3] = 1'b1;
        l_rgb[edge_n + 3] = v;
        l_name[edge_n + 3] = nm;
    endtask

    task automatic drive(input logic d, input logic h, input logic v,
                         input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        int slot, px, py, yl, o_r, o_g, o_b;
        slot = edge_n + 3;
        if (slot >= NSLOT) begin
            $display("FAIL slot_budget: got %0d, want < %0d", slot, NSLOT);
            $fatal(1);
        end
        de = d; hs = h; vs = v; r = rr; g = gg; b = bb;
        px = (m_pix > HA - 1) ? HA - 1 : m_pix;
        py = (m_line > VA - 1) ? VA - 1 : m_line;
        o_r = 0; o_g = 0; o_b = 0;
        if (d) begin
            yl = luma(rr, gg, bb);
            case (m_mode)
                0: begin o_r = rr; o_g = gg; o_b = bb; end
                1: begin o_r = yl; o_g = yl; o_b = yl; end
                2: begin o_r = (yl >= m_thr) ? 255 : 0; o_g = o_r; o_b = o_r; end
                default: begin o_r = 255 - rr; o_g = 255 - gg; o_b = 255 - bb; end
            endcase
`ifdef VIDEO_ROI_BOX_EN
            if (((px == m_x0 || px == m_x1) && py >= m_y0 && py <= m_y1) ||
                ((py == m_y0 || py == m_y1) && px >= m_x0 && px <= m_x1)) begin
                o_r = 255; o_g = 0; o_b = 0;
            end
`endif
            m_pix++;
        end
        ev[slot] = 1'b1;
        e_de[slot] = d; e_hs[slot] = h; e_vs[slot] = v;
        e_r[slot] = o_r; e_g[slot] = o_g; e_b[slot] = o_b;
        e_x[slot] = px; e_y[slot] = py;
        if (m_prev_de && !d) begin
            m_line++;
            m_pix = 0;
        end
        if (v && !m_prev_vs) begin
            m_line = 0;
            m_fc = (m_fc + 1) % 65536;
            m_mode = mode; m_thr = thr;
            m_x0 = x0; m_x1 = x1; m_y0 = y0; m_y1 = y1;
        end
        fv[edge_n + 1] = 1'b1;
        e_fc[edge_n + 1] = m_fc;
        m_prev_vs = v; m_prev_de = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic vsync_start();
        repeat (2) drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        idle(2);
    endtask

    task automatic hblank();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        idle(1);
    endtask

    task automatic line_const(input int n, input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        repeat (n) drive(1'b1, 1'b0, 1'b0, rr, gg, bb);
        hblank();
    endtask

    always @(negedge clk) begin
        int n;
        n = edge_n;
        if (rst_n && n < NSLOT) begin
            if (ev[n]) begin
                chk("tx_de", 32'(tx_de), 32'(e_de[n]));
                chk("tx_hsync", 32'(tx_hsync), 32'(e_hs[n]));
                chk("tx_vsync", 32'(tx_vsync), 32'(e_vs[n]));
                chk("tx_red", 32'(tx_red), e_r[n]);
                chk("tx_green", 32'(tx_green), e_g[n]);
                chk("tx_blue", 32'(tx_blue), e_b[n]);
                if (e_de[n]) begin
                    chk("tx_x", 32'(tx_x), e_x[n]);
                    chk("tx_y", 32'(tx_y), e_y[n]);
                end
            end
            if (fv[n]) chk("frame_cnt", 32'(frame_cnt), e_fc[n]);
            if (lv[n]) chk(l_name[n], {8'h00, tx_red, tx_green, tx_blue}, l_rgb[n]);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_de", 32'(tx_de), 0);
        chk("rst_sync", {30'd0, tx_hsync, tx_vsync}, 0);
        chk("rst_rgb", {8'h00, tx_red, tx_green, tx_blue}, 0);
        chk("rst_xy", {28'd0, tx_x, tx_y}, 0);
        chk("rst_fcnt", 32'(frame_cnt), 0);
        rst_n = 1'b1;
        reset_model();
        idle(2);

        // Pass mode, 4x4 frame (line count beyond V_ACT saturates tx_y).
        mode = 2'd0; thr = 8'h80;
        vsync_start();
        set_lit(32'h123456, "pass_first");
        drive(1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56);
        hblank();
        repeat (3) line_const(4, 8'h12, 8'h34, 8'h56);

        // Grayscale.
        mode = 2'd1;
        vsync_start();
        set_lit(32'hFFFFFF, "gray_white");
        drive(1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255);
        set_lit(32'h525252, "gray_82");
        drive(1'b1, 1'b0, 1'b0, 8'd100, 8'd50, 8'd200);
        drive(1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        hblank();
        line_const(4, 8'h40, 8'h80, 8'hC0);

        // Threshold; cfg present only on the rising vsync cycle is the one captured.
        mode = 2'd2; thr = 8'h80;
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        mode = 2'd0;
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        idle(2);
        set_lit(32'h000000, "thr_7f");
        drive(1'b1, 1'b0, 1'b0, 8'h7F, 8'h7F, 8'h7F);
        set_lit(32'hFFFFFF, "thr_80");
        drive(1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 8'h80);
        drive(1'b1, 1'b0, 1'b0, 8'd100, 8'd50, 8'd200);
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
        hblank();
        thr = 8'h10;
        set_lit(32'h000000, "thr_midframe");
        drive(1'b1, 1'b0, 1'b0, 8'h7F, 8'h7F, 8'h7F);
        drive(1'b1, 1'b0, 1'b0, 8'h20, 8'h20, 8'h20);
        hblank();
        mode = 2'd2;
        vsync_start();
        set_lit(32'hFFFFFF, "thr_new_frame");
        drive(1'b1, 1'b0, 1'b0, 8'h7F, 8'h7F, 8'h7F);
        drive(1'b1, 1'b0, 1'b0, 8'h08, 8'h08, 8'h08);
        hblank();

        // Invert, mid-frame mode write, 5-pixel line.
        mode = 2'd3; thr = 8'h80;
        vsync_start();
        set_lit(32'hF07F00, "invert");
        drive(1'b1, 1'b0, 1'b0, 8'h0F, 8'h80, 8'hFF);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        mode = 2'd1;
        drive(1'b1, 1'b0, 1'b0, 8'hAA, 8'h55, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56);
        drive(1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 8'h03);
        hblank();
        line_const(4, 8'h33, 8'h66, 8'h99);
        vsync_start();
        set_lit(32'h6C6C6C, "gray_after_vsync");
        drive(1'b1, 1'b0, 1'b0, 8'h0F, 8'h80, 8'hFF);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h21, 8'h43, 8'h65);
        hblank();
        repeat (3) line_const(4, 8'h90, 8'h10, 8'h50);

        // Asynchronous reset in the middle of a line.
        mode = 2'd3;
        vsync_start();
        for (int k = 1; k <= 5; k++) drive(1'b1, 1'b0, 1'b0, 8'(16 * k), 8'(8 * k), 8'(4 * k));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_de", 32'(tx_de), 0);
        chk("async_rst_rgb", {8'h00, tx_red, tx_green, tx_blue}, 0);
        chk("async_rst_x", 32'(tx_x), 0);
        chk("async_rst_fcnt", 32'(frame_cnt), 0);
        de = 1'b0; hs = 1'b0; vs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
        drive(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
        set_lit(32'h0F80FF, "pass_after_reset");
        drive(1'b1, 1'b0, 1'b0, 8'h0F, 8'h80, 8'hFF);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h44, 8'h55, 8'h66);
        hblank();
        vsync_start();
        line_const(4, 8'h0F, 8'h80, 8'hFF);

`ifdef VIDEO_ROI_BOX_EN
        mode = 2'd0;
        x0 = 2'd1; x1 = 2'd2; y0 = 2'd1; y1 = 2'd2;
        vsync_start();
        set_lit(32'h102030, "roi_outside");
        drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 8'h30);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 8'h30);
        hblank();
        drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 8'h30);
        set_lit(32'hFF0000, "roi_corner");
        drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 8'h30);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 8'h30);
        hblank();
        line_const(4, 8'h10, 8'h20, 8'h30);
`endif

        idle(6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
